// File: rtl/except_fetch_unit.sv
// Fetch-stage exception detector: flags breakpoint, page, access and alignment faults
// on the fetch PC, holds the winner until the trap unit takes it, and stalls fetch meanwhile.
module except_fetch_unit #(
    parameter int unsigned     N        = 64,
    parameter int unsigned     NUM_BP   = 4,
    parameter logic [N-1:0]    MEM_BASE = '0,
    parameter logic [N-1:0]    MEM_SIZE = N'(64'h10000)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           PC,
    input  logic                   fetchValid,
    input  logic                   iAlign,
    input  logic                   pageFault,
    input  logic                   bpWe,
    input  logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] bpIdx,
    input  logic [N-1:0]           bpAddr,
    input  logic                   bpEn,
    input  logic                   trapAck,
    input  logic                   flush,
    output logic                   exceptValid,
    output logic [3:0]             exceptSignal,
    output logic [N-1:0]           exceptPC,
    output logic                   stallF,
    output logic [15:0]            exceptCount
);

    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state, state_n;

    logic [N-1:0]      bp_addr [NUM_BP];
    logic [NUM_BP-1:0] bp_en;

    logic          misalign, access, page, bp, hit;
    logic [3:0]    win;
    logic [N:0]    pc_ext, base_ext, end_ext;

    logic          valid_n, stall_n;
    logic [3:0]    sig_n;
    logic [N-1:0]  pc_n;
    logic [CW-1:0] cnt_n;

    // Breakpoint slots; out-of-range indices are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_BP); i++) begin
                bp_addr[i] <= '0;
            end
            bp_en <= '0;
        end else if (bpWe && (32'(bpIdx) < NUM_BP)) begin
            bp_addr[bpIdx] <= bpAddr;
            bp_en[bpIdx]   <= bpEn;
        end
    end

    // Window bounds carried one bit wider so BASE+SIZE cannot wrap
    assign pc_ext   = {1'b0, PC};
    assign base_ext = {1'b0, MEM_BASE};
    assign end_ext  = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    always_comb begin
        misalign = iAlign ? PC[0] : (|PC[1:0]);
        access   = (pc_ext < base_ext) | (pc_ext >= end_ext);
        page     = pageFault;
        bp       = 1'b0;
        for (int i = 0; i < int'(NUM_BP); i++) begin
            bp = bp | (bp_en[i] & (bp_addr[i] == PC));
        end
        hit = fetchValid & (bp | page | access | misalign);
    end

    // Priority: breakpoint > page > access > misalign
    always_comb begin
        win = 4'b0000;
        if (bp)            win = 4'b1000;
        else if (page)     win = 4'b0100;
        else if (access)   win = 4'b0010;
        else if (misalign) win = 4'b0001;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        valid_n = 1'b0;
        stall_n = 1'b0;
        sig_n   = 4'b0000;
        pc_n    = exceptPC;
        cnt_n   = exceptCount;
        case (state)
            IDLE: begin
                if (hit && !flush) begin
                    state_n = PENDING;
                    valid_n = 1'b1;
                    stall_n = 1'b1;
                    sig_n   = win;
                    pc_n    = PC;
                    cnt_n   = (exceptCount == 16'hFFFF) ? exceptCount : exceptCount + 16'd1;
                end
            end
            PENDING: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (trapAck) begin
                    state_n = DRAIN;
                    stall_n = 1'b1;
                end else begin
                    valid_n = 1'b1;
                    stall_n = 1'b1;
                    sig_n   = exceptSignal;
                end
            end
            DRAIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exceptValid  <= 1'b0;
            exceptSignal <= 4'b0000;
            exceptPC     <= '0;
            stallF       <= 1'b0;
            exceptCount  <= '0;
        end else begin
            exceptValid  <= valid_n;
            exceptSignal <= sig_n;
            exceptPC     <= pc_n;
            stallF       <= stall_n;
            exceptCount  <= cnt_n;
        end
    end

endmodule

// File: tb/tb_except_fetch_unit.sv
// Directed bench for except_fetch_unit: inputs change and outputs are sampled on the falling edge.
module tb_except_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] PC;
    logic        fetchValid, iAlign, pageFault;
    logic        bpWe;
    logic [1:0]  bpIdx;
    logic [63:0] bpAddr;
    logic        bpEn, trapAck, flush;
    logic        exceptValid;
    logic [3:0]  exceptSignal;
    logic [63:0] exceptPC;
    logic        stallF;
    logic [15:0] exceptCount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    except_fetch_unit dut (
        .clk(clk), .reset(reset), .PC(PC), .fetchValid(fetchValid), .iAlign(iAlign),
        .pageFault(pageFault), .bpWe(bpWe), .bpIdx(bpIdx), .bpAddr(bpAddr), .bpEn(bpEn),
        .trapAck(trapAck), .flush(flush), .exceptValid(exceptValid),
        .exceptSignal(exceptSignal), .exceptPC(exceptPC), .stallF(stallF),
        .exceptCount(exceptCount)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [3:0] s,
                           input logic [63:0] p, input logic st, input logic [15:0] c);
        chk({tag, ".valid"}, 64'(exceptValid), 64'(v));
        chk({tag, ".sig"},   64'(exceptSignal), 64'(s));
        chk({tag, ".pc"},    exceptPC, p);
        chk({tag, ".stall"}, 64'(stallF), 64'(st));
        chk({tag, ".count"}, 64'(exceptCount), 64'(c));
    endtask

    initial begin
        reset = 1'b1; PC = '0; fetchValid = 1'b0; iAlign = 1'b0; pageFault = 1'b0;
        bpWe = 1'b0; bpIdx = '0; bpAddr = '0; bpEn = 1'b0; trapAck = 1'b0; flush = 1'b0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        chk_all("reset", 1'b0, 4'b0000, 64'h0, 1'b0, 16'd0);

        // Aligned in-window fetch: nothing
        PC = 64'h100; fetchValid = 1'b1; iAlign = 1'b0;
        step();
        chk_all("clean", 1'b0, 4'b0000, 64'h0, 1'b0, 16'd0);

        // 2-byte aligned PC is legal under C ext
        PC = 64'h102; iAlign = 1'b1;
        step();
        chk("calign.valid", 64'(exceptValid), 64'd0);

        iAlign = 1'b0;
        step();
        chk_all("misalign", 1'b1, 4'b0001, 64'h102, 1'b1, 16'd1);

        // New PCs ignored while pending
        PC = 64'h401; pageFault = 1'b1;
        step();
        chk_all("hold", 1'b1, 4'b0001, 64'h102, 1'b1, 16'd1);

        pageFault = 1'b0; fetchValid = 1'b0; trapAck = 1'b1;
        step();
        chk_all("drain", 1'b0, 4'b0000, 64'h102, 1'b1, 16'd1);
        trapAck = 1'b0;
        step();
        chk_all("idle_after_drain", 1'b0, 4'b0000, 64'h102, 1'b0, 16'd1);

        // Breakpoint write: same-cycle compare still sees the old (disabled) slot
        bpWe = 1'b1; bpIdx = 2'd2; bpAddr = 64'h200; bpEn = 1'b1;
        PC = 64'h200; fetchValid = 1'b1;
        step();
        chk("bp_same_cycle.valid", 64'(exceptValid), 64'd0);
        bpWe = 1'b0; pageFault = 1'b1;
        step();
        chk_all("bp_wins", 1'b1, 4'b1000, 64'h200, 1'b1, 16'd2);
        pageFault = 1'b0; fetchValid = 1'b0; trapAck = 1'b1;
        step();
        trapAck = 1'b0;
        chk("bp_ack1.stall", 64'(stallF), 64'd1);
        step();
        chk("bp_ack2.stall", 64'(stallF), 64'd0);

        // Page fault alone, then flush+trapAck skips DRAIN
        PC = 64'h204; fetchValid = 1'b1; pageFault = 1'b1;
        step();
        chk_all("page", 1'b1, 4'b0100, 64'h204, 1'b1, 16'd3);
        pageFault = 1'b0; flush = 1'b1; trapAck = 1'b1;
        step();
        chk_all("flush_ack", 1'b0, 4'b0000, 64'h204, 1'b0, 16'd3);
        trapAck = 1'b0;

        // Hit masked by flush in IDLE
        PC = 64'h10000;
        step();
        chk_all("flush_mask", 1'b0, 4'b0000, 64'h204, 1'b0, 16'd3);
        flush = 1'b0;
        step();
        chk_all("access_edge", 1'b1, 4'b0010, 64'h10000, 1'b1, 16'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        PC = 64'hFFFC;
        step();
        chk("last_word.valid", 64'(exceptValid), 64'd0);

        // Access fault outranks misalignment
        PC = 64'h10002;
        step();
        chk_all("access_over_mis", 1'b1, 4'b0010, 64'h10002, 1'b1, 16'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetchValid = 1'b0;
        step();

        // Preload counter one short of saturation
        force dut.exceptCount = 16'hFFFE;
        #1;
        release dut.exceptCount;
        PC = 64'h102; fetchValid = 1'b1;
        step();
        chk_all("count_to_max", 1'b1, 4'b0001, 64'h102, 1'b1, 16'hFFFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        PC = 64'h106;
        step();
        chk_all("count_sat", 1'b1, 4'b0001, 64'h106, 1'b1, 16'hFFFF);

        // Reset mid-PENDING clears everything, including breakpoints
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all("reset_pending", 1'b0, 4'b0000, 64'h0, 1'b0, 16'd0);
        PC = 64'h200; fetchValid = 1'b1;
        step();
        chk("bp_cleared.valid", 64'(exceptValid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
